// File: rtl/ndn_pkg.sv
// Shared definitions for the name datapath: default name geometry and the
// assembler FSM state encoding, used by the assembler, the top and the lookup engine.
package ndn_pkg;

    // Default width of one name component word.
    localparam int unsigned NDN_WORD_SIZE       = 32;
    // Default maximum number of words in one name.
    localparam int unsigned NDN_MAX_NAME_LENGTH = 8;
    // Width of the name length field handed to the lookup engine.
    localparam int unsigned NDN_NAME_LEN_W      = 4;

    // Name assembler states.
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } asm_state_e;

endpackage

// File: rtl/name_assembler.sv
// Name assembler: gathers a stream of name component words into one
// parallel name for the lookup engine. Names longer than MAX_NAME_LENGTH
// are swallowed whole, flagged with a one-cycle error pulse and counted.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_COLLECT | accepting words; cnt = words stored so far for this name
// ST_HOLD    | complete name presented, waiting for the lookup engine
// ST_DISCARD | overflowed name; accept and drop words until word_last
module name_assembler
    import ndn_pkg::*;
#(
    parameter int unsigned WORD_SIZE       = NDN_WORD_SIZE,
    parameter int unsigned MAX_NAME_LENGTH = NDN_MAX_NAME_LENGTH,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [WORD_SIZE-1:0]                        word_in,
    input  logic                                        word_valid,
    input  logic                                        word_last,
    output logic                                        word_ready,
    output logic [MAX_NAME_LENGTH-1:0][WORD_SIZE-1:0]   name_out,
    output logic [NDN_NAME_LEN_W-1:0]                   name_len,
    output logic                                        name_valid,
    input  logic                                        name_ready,
    output logic                                        name_err,
    output logic [CNT_WIDTH-1:0]                        drop_count
);

    // cnt must be able to hold MAX_NAME_LENGTH itself (the "full" marker).
    localparam int unsigned       IDX_W    = $clog2(MAX_NAME_LENGTH + 1);
    localparam logic [IDX_W-1:0]  IDX_FULL = IDX_W'(MAX_NAME_LENGTH);

    asm_state_e                                 state_q, state_d;
    logic [IDX_W-1:0]                           cnt_q, cnt_d;
    logic [MAX_NAME_LENGTH-1:0][WORD_SIZE-1:0]  name_q, name_d;
    logic [NDN_NAME_LEN_W-1:0]                  len_q, len_d;
    logic                                       err_q, err_d;
    logic [CNT_WIDTH-1:0]                       drop_q, drop_d;

    logic word_xfer;
    logic name_xfer;
    logic name_full;
    logic enter_collect;
    logic drop_name;

    assign word_xfer = word_valid & word_ready;
    assign name_xfer = name_valid & name_ready;
    assign name_full = (cnt_q == IDX_FULL);

    // Entering COLLECT (from any state, including an overflowed name that
    // ends while still in COLLECT) wipes the name buffer so unused words of
    // the next held name read as zero.
    assign enter_collect = (state_d == ST_COLLECT) &&
                           ((state_q != ST_COLLECT) || (word_xfer && word_last));

    // The last word of a name that did not fit ends a dropped name.
    assign drop_name = word_xfer && word_last &&
                       (((state_q == ST_COLLECT) && name_full) ||
                        (state_q == ST_DISCARD));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_COLLECT: begin
                if (word_xfer) begin
                    if (name_full) begin
                        state_d = word_last ? ST_COLLECT : ST_DISCARD;
                    end else if (word_last) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (name_xfer) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_DISCARD: begin
                if (word_xfer && word_last) begin
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    // FSM outputs: handshakes depend on the current state only.
    always_comb begin
        word_ready = 1'b1;
        name_valid = 1'b0;
        unique case (state_q)
            ST_COLLECT: begin
                word_ready = 1'b1;
                name_valid = 1'b0;
            end
            ST_HOLD: begin
                word_ready = 1'b0;
                name_valid = 1'b1;
            end
            ST_DISCARD: begin
                word_ready = 1'b1;
                name_valid = 1'b0;
            end
            default: begin
                word_ready = 1'b1;
                name_valid = 1'b0;
            end
        endcase
    end

    // Datapath next state: word storage, length capture, drop accounting.
    always_comb begin
        cnt_d  = cnt_q;
        name_d = name_q;
        len_d  = len_q;
        err_d  = 1'b0;
        drop_d = drop_q;

        if (enter_collect) begin
            cnt_d  = '0;
            name_d = '0;
            len_d  = '0;
        end else if ((state_q == ST_COLLECT) && word_xfer && !name_full) begin
            // Decode the slot by compare so the index width never has to
            // match the array bound.
            for (int i = 0; i < int'(MAX_NAME_LENGTH); i++) begin
                if (cnt_q == IDX_W'(i)) begin
                    name_d[i] = word_in;
                end
            end
            cnt_d = cnt_q + IDX_W'(1);
            if (word_last) begin
                len_d = NDN_NAME_LEN_W'(cnt_q) + NDN_NAME_LEN_W'(1);
            end
        end

        if (drop_name) begin
            err_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + CNT_WIDTH'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            name_q <= '0;
            len_q  <= '0;
            err_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            name_q <= name_d;
            len_q  <= len_d;
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    assign name_out   = name_q;
    assign name_len   = len_q;
    assign name_err   = err_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_name_assembler.sv
// Directed bench for name_assembler with a scoreboard of expected names.
module tb_name_assembler;

    localparam int WS  = 32;
    localparam int ML  = 8;
    localparam int CW  = 3;

    typedef struct packed {
        logic [ML-1:0][WS-1:0] data;
        logic [3:0]            len;
    } exp_t;

    logic                   clk;
    logic                   rst_n;
    logic [WS-1:0]          word_in;
    logic                   word_valid;
    logic                   word_last;
    logic                   word_ready;
    logic [ML-1:0][WS-1:0]  name_out;
    logic [3:0]             name_len;
    logic                   name_valid;
    logic                   name_ready;
    logic                   name_err;
    logic [CW-1:0]          drop_count;

    name_assembler #(
        .WORD_SIZE       (WS),
        .MAX_NAME_LENGTH (ML),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_last  (word_last),
        .word_ready (word_ready),
        .name_out   (name_out),
        .name_len   (name_len),
        .name_valid (name_valid),
        .name_ready (name_ready),
        .name_err   (name_err),
        .drop_count (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int     checks = 0;
    int     errors = 0;
    int     names_rx = 0;
    int     names_tx = 0;
    int     err_cnt = 0;
    int     ready_low_cnt = 0;
    int     err_base;
    bit     xfer_seen = 0;
    exp_t   exp_q[$];
    logic [WS-1:0] wbuf [16];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        xfer_seen = word_valid && word_ready;
        if (!word_ready) ready_low_cnt++;
        if (name_err) err_cnt++;
        if (name_valid && name_ready) begin
            names_rx++;
            chk("sb_has_entry", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_name_len", name_len, e.len);
                chk("sb_name_out", name_out, e.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int n);
        exp_t e;
        e.data = '0;
        for (int i = 0; i < n; i++) e.data[i] = wbuf[i];
        e.len = 4'(n);
        exp_q.push_back(e);
        names_tx++;
    endtask

    task automatic send_name(input int n, input bit last_on_final, input bit push);
        int guard;
        if (push) push_exp(n);
        for (int i = 0; i < n; i++) begin
            word_in    = wbuf[i];
            word_valid = 1'b1;
            word_last  = last_on_final && (i == n - 1);
            guard = 0;
            do begin
                tick();
                guard++;
            end while (!xfer_seen && guard < 50);
            if (!xfer_seen) chk("word_accept_timeout", xfer_seen, 1'b1);
        end
        word_valid = 1'b0;
        word_last  = 1'b0;
        word_in    = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t hold_exp;
        int   guard;

        rst_n      = 1'b0;
        word_in    = '0;
        word_valid = 1'b0;
        word_last  = 1'b0;
        name_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_name_valid", name_valid, 1'b0);
        chk("rst_name_out",   name_out,   '0);
        chk("rst_name_len",   name_len,   4'd0);
        chk("rst_name_err",   name_err,   1'b0);
        chk("rst_drop_count", drop_count, 3'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_word_ready", word_ready, 1'b1);

        // Three-word name, consumer always ready
        name_ready = 1'b1;
        wbuf[0] = 32'hA1; wbuf[1] = 32'hB2; wbuf[2] = 32'hC3;
        send_name(3, 1'b1, 1'b1);
        chk("n3_valid_latency", name_valid, 1'b1);
        chk("n3_len",           name_len,   4'd3);
        chk("n3_word_ready",    word_ready, 1'b0);
        tick();
        chk("n3_held_one_cycle", name_valid, 1'b0);
        chk("n3_ready_back",     word_ready, 1'b1);

        // Full-length name under 5 cycles of backpressure
        name_ready = 1'b0;
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h10 + i;
        send_name(8, 1'b1, 1'b1);
        hold_exp.data = '0;
        for (int i = 0; i < 8; i++) hold_exp.data[i] = 32'h10 + i;
        for (int c = 0; c < 5; c++) begin
            chk("n8_hold_valid",      name_valid, 1'b1);
            chk("n8_hold_word_ready", word_ready, 1'b0);
            chk("n8_hold_len",        name_len,   4'd8);
            chk("n8_hold_data",       name_out,   hold_exp.data);
            tick();
        end
        name_ready = 1'b1;
        tick();
        chk("n8_released",     name_valid, 1'b0);
        chk("n8_ready_back",   word_ready, 1'b1);

        // Single-word name
        wbuf[0] = 32'hDEADBEEF;
        send_name(1, 1'b1, 1'b1);
        chk("n1_valid", name_valid, 1'b1);
        chk("n1_len",   name_len,   4'd1);
        tick();

        // Ten-word name overflows and is dropped
        err_base = err_cnt;
        for (int i = 0; i < 10; i++) wbuf[i] = 32'h20 + i;
        send_name(10, 1'b1, 1'b0);
        chk("ovf10_err_pulse",  name_err,   1'b1);
        chk("ovf10_drop_count", drop_count, 3'd1);
        chk("ovf10_no_valid",   name_valid, 1'b0);
        tick();
        chk("ovf10_err_one_cycle", name_err, 1'b0);
        chk("ovf10_err_count", err_cnt - err_base, 1);

        // Nine-word name: last word arrives with the buffer already full
        for (int i = 0; i < 9; i++) wbuf[i] = 32'h90 + i;
        send_name(9, 1'b1, 1'b0);
        chk("ovf9_err_pulse",  name_err,   1'b1);
        chk("ovf9_drop_count", drop_count, 3'd2);
        chk("ovf9_no_valid",   name_valid, 1'b0);
        tick();

        // Next short name after overflow: stale words must be zero
        wbuf[0] = 32'h30; wbuf[1] = 32'h31;
        send_name(2, 1'b1, 1'b1);
        chk("post_ovf_valid", name_valid, 1'b1);
        chk("post_ovf_len",   name_len,   4'd2);
        tick();

        // Back-to-back names with word_valid held high
        wbuf[0] = 32'h40; wbuf[1] = 32'h41; wbuf[2] = 32'h42;
        push_exp(3);
        wbuf[0] = 32'h50; wbuf[1] = 32'h51;
        push_exp(2);
        wbuf[0] = 32'h40; wbuf[1] = 32'h41; wbuf[2] = 32'h42;
        wbuf[3] = 32'h50; wbuf[4] = 32'h51;
        ready_low_cnt = 0;
        word_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            word_in   = wbuf[i];
            word_last = (i == 2) || (i == 4);
            guard = 0;
            do begin
                tick();
                guard++;
            end while (!xfer_seen && guard < 50);
            if (!xfer_seen) chk("b2b_accept_timeout", xfer_seen, 1'b1);
        end
        chk("b2b_bubble_cycles", ready_low_cnt, 1);
        word_valid = 1'b0;
        word_last  = 1'b0;
        tick();
        chk("b2b_all_delivered", exp_q.size(), 0);

        // Reset in the middle of a name
        err_base = err_cnt;
        for (int i = 0; i < 6; i++) wbuf[i] = 32'h60 + i;
        send_name(4, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_word_ready", word_ready, 1'b1);
        chk("midrst_name_valid", name_valid, 1'b0);
        chk("midrst_name_out",   name_out,   '0);
        chk("midrst_name_len",   name_len,   4'd0);
        chk("midrst_drop_count", drop_count, 3'd0);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        chk("midrst_no_err", err_cnt - err_base, 0);
        wbuf[0] = 32'h70; wbuf[1] = 32'h71; wbuf[2] = 32'h72;
        send_name(3, 1'b1, 1'b1);
        chk("midrst_next_valid", name_valid, 1'b1);
        chk("midrst_next_len",   name_len,   4'd3);
        tick();
        chk("midrst_drop_kept", drop_count, 3'd0);

        // Reset while holding a name
        name_ready = 1'b0;
        wbuf[0] = 32'h80; wbuf[1] = 32'h81;
        send_name(2, 1'b1, 1'b0);
        chk("holdrst_valid_before", name_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("holdrst_valid", name_valid, 1'b0);
        chk("holdrst_ready", word_ready, 1'b1);
        #1;
        rst_n = 1'b1;
        name_ready = 1'b1;
        tick();
        chk("holdrst_drop", drop_count, 3'd0);
        chk("holdrst_no_err", err_cnt - err_base, 0);

        // Drop counter saturation
        err_base = err_cnt;
        for (int i = 0; i < 9; i++) wbuf[i] = 32'hC0 + i;
        for (int k = 0; k < 9; k++) send_name(9, 1'b1, 1'b0);
        tick();
        chk("sat_drop_count", drop_count, 3'd7);
        chk("sat_err_pulses", err_cnt - err_base, 9);

        // Scoreboard drained
        chk("sb_empty", exp_q.size(), 0);
        chk("sb_count", names_rx, names_tx);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
